// File: rtl/corelet_ctrl.sv
// corelet_ctrl: tile sequencer for the corelet.
// Steps one tile through weight fill/load/settle, activation fill/execute and
// output drain, driving the corelet instruction bus, SRAM read port and psum
// write port. Every output is a flop; the FSM decides in cycle N and the
// strobe becomes visible in cycle N+1.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start, all outputs low
// W_FILL   | read col weight words from SRAM into L0
// W_LOAD   | pop col words from L0 into the array (load)
// W_SETTLE | row+col quiet cycles while weights propagate
// X_FILL   | read n_act activation vectors from SRAM into L0
// X_EXEC   | pop n_act vectors from L0 into the array (execute)
// DRAIN    | read n_act rows from OFIFO, write them to psum memory
// DONE     | one-cycle completion pulse

module corelet_ctrl #(
    parameter int ROW    = 8,
    parameter int COL    = 8,
    parameter int ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [7:0]        n_act_i,
    input  logic              acc_en_i,
    input  logic [ADDR_W-1:0] w_base_i,
    input  logic [ADDR_W-1:0] x_base_i,
    input  logic [ADDR_W-1:0] p_base_i,
    input  logic              l0_full_i,
    input  logic              l0_ready_i,
    input  logic              ofifo_valid_i,
    output logic [33:0]       inst_o,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              psum_wr_o,
    output logic [ADDR_W-1:0] psum_addr_o,
    output logic              busy_o,
    output logic              done_o
);

    // Counter must hold col, 255 activations and row+col-1 settle cycles.
    localparam int CNT_W = 9;
    localparam logic [CNT_W-1:0] COL_C       = CNT_W'(COL);
    localparam logic [CNT_W-1:0] COL_LAST    = CNT_W'(COL - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(ROW + COL - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_FILL   = 3'd1,
        W_LOAD   = 3'd2,
        W_SETTLE = 3'd3,
        X_FILL   = 3'd4,
        X_EXEC   = 3'd5,
        DRAIN    = 3'd6,
        DONE     = 3'd7
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        n_act_q;
    logic              acc_en_q;
    logic [ADDR_W-1:0] w_base_q, x_base_q, p_base_q;
    logic              cfg_load;
    logic [CNT_W-1:0]  n_act_ext;

    logic              mem_rd_d, load_d, exec_d, ofrd_d, busy_d, done_d;
    logic [ADDR_W-1:0] mem_addr_d, pend_addr_d;

    logic              mem_rd_q, load_q, exec_q, l0_wr_q, ofrd_q;
    logic              psum_wr_q, acc_str_q, busy_q, done_q;
    logic [ADDR_W-1:0] mem_addr_q, pend_addr_q, psum_addr_q;

    assign cfg_load  = (state_q == IDLE) && start_i;
    assign n_act_ext = {1'b0, n_act_q};

    // State, phase counter and tile configuration captured at start.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            n_act_q  <= '0;
            acc_en_q <= 1'b0;
            w_base_q <= '0;
            x_base_q <= '0;
            p_base_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cfg_load) begin
                n_act_q  <= n_act_i;
                acc_en_q <= acc_en_i;
                w_base_q <= w_base_i;
                x_base_q <= x_base_i;
                p_base_q <= p_base_i;
            end
        end
    end

    // Next state; the fill phases linger one cycle after the last issue so
    // the in-flight word lands before the L0 read phase begins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = W_FILL;
                    cnt_d   = '0;
                end
            end
            W_FILL: begin
                if (cnt_q == COL_C) begin
                    state_d = W_LOAD;
                    cnt_d   = '0;
                end else if (!l0_full_i) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            W_LOAD: begin
                if (l0_ready_i) begin
                    if (cnt_q == COL_LAST) begin
                        state_d = W_SETTLE;
                        cnt_d   = SETTLE_LAST;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            W_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = (n_act_q == 8'd0) ? DONE : X_FILL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            X_FILL: begin
                if (cnt_q == n_act_ext) begin
                    state_d = X_EXEC;
                    cnt_d   = '0;
                end else if (!l0_full_i) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            X_EXEC: begin
                if (l0_ready_i) begin
                    if (cnt_q == n_act_ext - 1'b1) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == n_act_ext) begin
                    state_d = DONE;
                end else if (ofifo_valid_i) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobe decisions for this cycle; they reach the pins one cycle later.
    always_comb begin
        mem_rd_d    = 1'b0;
        mem_addr_d  = '0;
        load_d      = 1'b0;
        exec_d      = 1'b0;
        ofrd_d      = 1'b0;
        pend_addr_d = '0;
        busy_d      = (state_q != IDLE);
        done_d      = (state_q == DONE);
        case (state_q)
            W_FILL: begin
                if (!l0_full_i && (cnt_q < COL_C)) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = w_base_q + ADDR_W'(cnt_q);
                end
            end
            W_LOAD: load_d = l0_ready_i;
            X_FILL: begin
                if (!l0_full_i && (cnt_q < n_act_ext)) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = x_base_q + ADDR_W'(cnt_q);
                end
            end
            X_EXEC: exec_d = l0_ready_i;
            DRAIN: begin
                if (ofifo_valid_i && (cnt_q < n_act_ext)) begin
                    ofrd_d      = 1'b1;
                    pend_addr_d = p_base_q + ADDR_W'(cnt_q);
                end
            end
            default: ;
        endcase
    end

    // Output flops; l0_wr trails mem_rd and psum_wr trails the OFIFO read.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            load_q      <= 1'b0;
            exec_q      <= 1'b0;
            l0_wr_q     <= 1'b0;
            ofrd_q      <= 1'b0;
            pend_addr_q <= '0;
            psum_wr_q   <= 1'b0;
            psum_addr_q <= '0;
            acc_str_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            load_q      <= load_d;
            exec_q      <= exec_d;
            l0_wr_q     <= mem_rd_q;
            ofrd_q      <= ofrd_d;
            pend_addr_q <= pend_addr_d;
            psum_wr_q   <= ofrd_q;
            psum_addr_q <= ofrd_q ? pend_addr_q : '0;
            acc_str_q   <= ofrd_q & acc_en_q;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign inst_o = {acc_str_q, 26'd0, ofrd_q, 2'b00,
                     load_q | exec_q, l0_wr_q, exec_q, load_q};

    assign mem_rd_o    = mem_rd_q;
    assign mem_addr_o  = mem_addr_q;
    assign psum_wr_o   = psum_wr_q;
    assign psum_addr_o = psum_addr_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: scoreboard bench for the corelet tile sequencer.
module tb_corelet_ctrl;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int AW  = 11;

    localparam int M_NONE   = 0;
    localparam int M_STALL  = 1;
    localparam int M_GAP    = 2;
    localparam int M_RESET  = 3;
    localparam int M_START2 = 4;

    localparam logic [33:0] INST_MASK = 34'h2_0000_004F;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    n_act = 8'd0;
    logic          acc_en = 1'b0;
    logic [AW-1:0] w_base = '0;
    logic [AW-1:0] x_base = '0;
    logic [AW-1:0] p_base = '0;
    logic          l0_full = 1'b0;
    logic          l0_ready = 1'b1;
    logic          ofifo_valid = 1'b1;

    logic [33:0]   inst;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic          psum_wr;
    logic [AW-1:0] psum_addr;
    logic          busy;
    logic          done;

    corelet_ctrl #(.ROW(ROW), .COL(COL), .ADDR_W(AW)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .n_act_i      (n_act),
        .acc_en_i     (acc_en),
        .w_base_i     (w_base),
        .x_base_i     (x_base),
        .p_base_i     (p_base),
        .l0_full_i    (l0_full),
        .l0_ready_i   (l0_ready),
        .ofifo_valid_i(ofifo_valid),
        .inst_o       (inst),
        .mem_rd_o     (mem_rd),
        .mem_addr_o   (mem_addr),
        .psum_wr_o    (psum_wr),
        .psum_addr_o  (psum_addr),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard state
    logic [AW-1:0] mem_q[$];
    logic [AW-1:0] psum_q[$];
    logic [AW-1:0] exp_a;
    logic          acc_cur = 1'b0;
    logic          prev_mem_rd = 1'b0;
    logic          prev_ofrd = 1'b0;
    int mon_cyc = 0;
    int n_mem_rd, n_l0_wr, n_load, n_exec, n_ofifo, n_psum, n_acc, n_done;
    int last_load_cyc, first_xrd_cyc;

    function automatic int tile_len(input int n);
        if (n == 0) return 1 + (COL + 1) + COL + (ROW + COL) + 1;
        return 1 + (COL + 1) + COL + (ROW + COL) + (n + 1) + n + (n + 1) + 1;
    endfunction

    // Output monitor: inputs change only on negedge, so the value seen here
    // is the one the DUT sampled at the edge that produced these outputs.
    always @(posedge clk) begin
        #1;
        mon_cyc++;
        if (rst_n) begin
            check_val("l0_wr_follows_mem_rd", 64'(inst[2]), 64'(prev_mem_rd));
            check_val("psum_wr_follows_rd", 64'(psum_wr), 64'(prev_ofrd));
            check_val("acc_strobe", 64'(inst[33]), 64'(psum_wr & acc_cur));
            check_val("load_exec_excl", 64'(inst[0] & inst[1]), '0);
            check_val("l0_wr_rd_excl", 64'(inst[2] & inst[3]), '0);
            check_val("l0_rd_eq_ld_or_ex", 64'(inst[3]), 64'(inst[0] | inst[1]));
            check_val("reserved_bits", 64'(inst & ~INST_MASK), '0);
            if (inst[0] | inst[1]) check_val("l0_rd_needs_ready", 64'(l0_ready), 64'd1);
            if (inst[6]) check_val("ofifo_rd_needs_valid", 64'(ofifo_valid), 64'd1);
            if (mem_rd) begin
                check_val("mem_rd_blocked_by_full", 64'(l0_full), '0);
                if (mem_q.size() == 0) begin
                    check_val("mem_rd_unexpected", 64'(mem_rd), '0);
                end else begin
                    exp_a = mem_q.pop_front();
                    check_val("mem_addr", 64'(mem_addr), 64'(exp_a));
                end
                if (n_mem_rd == COL) first_xrd_cyc = mon_cyc;
                n_mem_rd++;
            end
            if (psum_wr) begin
                if (psum_q.size() == 0) begin
                    check_val("psum_wr_unexpected", 64'(psum_wr), '0);
                end else begin
                    exp_a = psum_q.pop_front();
                    check_val("psum_addr", 64'(psum_addr), 64'(exp_a));
                end
                n_psum++;
            end
            if (inst[0]) begin
                n_load++;
                last_load_cyc = mon_cyc;
            end
            if (inst[1]) n_exec++;
            if (inst[2]) n_l0_wr++;
            if (inst[6]) n_ofifo++;
            if (inst[33]) n_acc++;
            if (done) n_done++;
        end
        prev_mem_rd = rst_n ? mem_rd : 1'b0;
        prev_ofrd   = rst_n ? inst[6] : 1'b0;
    end

    task automatic check_outputs_zero();
        check_val("rst_inst", 64'(inst), '0);
        check_val("rst_mem_rd", 64'(mem_rd), '0);
        check_val("rst_mem_addr", 64'(mem_addr), '0);
        check_val("rst_psum_wr", 64'(psum_wr), '0);
        check_val("rst_psum_addr", 64'(psum_addr), '0);
        check_val("rst_busy", 64'(busy), '0);
        check_val("rst_done", 64'(done), '0);
    endtask

    task automatic run_tile(input logic [7:0] n, input logic acc, input logic [AW-1:0] wb,
                            input logic [AW-1:0] xb, input logic [AW-1:0] pb,
                            input int mode, input int exp_cyc);
        int cycles;
        int stall_left;
        bit did;
        bit aborted;
        bit timed_out;
        cycles = 0;
        stall_left = 0;
        did = 0;
        aborted = 0;
        timed_out = 0;
        mem_q.delete();
        psum_q.delete();
        for (int i = 0; i < COL; i++) mem_q.push_back(wb + AW'(i));
        for (int i = 0; i < int'(n); i++) begin
            mem_q.push_back(xb + AW'(i));
            psum_q.push_back(pb + AW'(i));
        end
        n_mem_rd = 0; n_l0_wr = 0; n_load = 0; n_exec = 0;
        n_ofifo = 0; n_psum = 0; n_acc = 0; n_done = 0;
        last_load_cyc = 0; first_xrd_cyc = 0;

        @(negedge clk);
        n_act = n; acc_en = acc; w_base = wb; x_base = xb; p_base = pb;
        acc_cur = acc;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        check_val("busy_lags_start", 64'(busy), '0);

        while (1) begin
            @(negedge clk);
            if (mode == M_GAP) begin
                ofifo_valid = ~ofifo_valid;
                l0_ready    = ~l0_ready;
            end
            if (mode == M_STALL && !did && n_mem_rd >= COL + 12) begin
                did = 1;
                stall_left = 3;
            end
            l0_full = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            start = 1'b0;
            if (mode == M_START2 && !did && n_ofifo == 3) begin
                did = 1;
                start = 1'b1;
            end
            if (mode == M_RESET && !did && n_exec == 5) begin
                did = 1;
                rst_n = 1'b0;
                #1;
                check_outputs_zero();
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (30) @(posedge clk);
                #2;
                check_val("no_done_after_reset", 64'(n_done), '0);
                check_val("idle_after_reset", 64'(busy), '0);
                check_val("no_rd_after_reset", 64'(mem_rd), '0);
                aborted = 1;
                break;
            end
            @(posedge clk);
            #2;
            cycles++;
            if (cycles == 1) begin
                check_val("busy_first", 64'(busy), 64'd1);
                check_val("mem_rd_first", 64'(mem_rd), 64'd1);
                check_val("mem_addr_first", 64'(mem_addr), 64'(wb));
            end
            if (done) break;
            if (cycles >= 3000) begin
                check_val("done_timeout", 64'(done), 64'd1);
                timed_out = 1;
                break;
            end
        end

        start = 1'b0;
        l0_full = 1'b0;
        l0_ready = 1'b1;
        ofifo_valid = 1'b1;

        if (!aborted && !timed_out) begin
            if (exp_cyc > 0) check_val("tile_cycles", 64'(cycles), 64'(exp_cyc - 1));
            check_val("mem_rd_count", 64'(n_mem_rd), 64'(COL + int'(n)));
            check_val("l0_wr_count_pre", 64'(n_l0_wr), 64'(COL + int'(n) - 0));
            check_val("load_count", 64'(n_load), 64'(COL));
            check_val("exec_count", 64'(n_exec), 64'(n));
            check_val("ofifo_rd_count", 64'(n_ofifo), 64'(n));
            check_val("psum_wr_count", 64'(n_psum), 64'(n));
            check_val("acc_count", 64'(n_acc), acc ? 64'(n) : 64'd0);
            check_val("mem_q_empty", 64'(mem_q.size()), '0);
            check_val("psum_q_empty", 64'(psum_q.size()), '0);
            if (n != 0) check_val("settle_gap", 64'(first_xrd_cyc - last_load_cyc), 64'(ROW + COL + 1));
            @(posedge clk);
            #2;
            check_val("done_one_cycle", 64'(done), '0);
            repeat (5) @(posedge clk);
            #2;
            check_val("idle_after_tile", 64'(busy), '0);
            check_val("done_count", 64'(n_done), 64'd1);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check_outputs_zero();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // plain tile, no stalls
        run_tile(8'd16, 1'b0, 11'd0, 11'd64, 11'd128, M_NONE, tile_len(16));
        // L0 full for three cycles mid activation fill
        run_tile(8'd16, 1'b0, 11'd100, 11'd200, 11'd300, M_STALL, tile_len(16) + 3);
        // OFIFO and L0 data gaps with accumulate on
        run_tile(8'd16, 1'b1, 11'd8, 11'd500, 11'd900, M_GAP, 0);
        // no activations: weight phases then done
        run_tile(8'd0, 1'b1, 11'd16, 11'd32, 11'd48, M_NONE, tile_len(0));
        // reset mid execute, then a clean tile
        run_tile(8'd16, 1'b1, 11'd0, 11'd64, 11'd128, M_RESET, 0);
        run_tile(8'd16, 1'b1, 11'd0, 11'd64, 11'd128, M_NONE, tile_len(16));
        // start in DRAIN ignored, addresses wrap
        run_tile(8'd8, 1'b0, 11'd2044, 11'd2046, 11'd2045, M_START2, tile_len(8));
        repeat (20) @(posedge clk);
        #2;
        check_val("no_restart_busy", 64'(busy), '0);
        check_val("no_restart_done", 64'(n_done), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/corelet_ctrl.md
# corelet_ctrl

Tile sequencer for the corelet. It drives the corelet's 34-bit `inst` bus and the activation/weight SRAM read port through one complete tile: weight fill, weight load, activation fill, execute, and output drain. It also issues psum-memory write strobes for drained rows, and optionally accumulate strobes into the SFP. It sits between the top-level testbench/host and the corelet.

## Interface
- `row`, 8: MAC array rows; L0 width in lanes.
- `col`, 8: MAC array columns; number of weight words per tile.
- `addr_w`, 11: SRAM and psum address width.
- `clk` in 1: master clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low. Low forces all state and outputs to reset values immediately.
- `start` in 1: one-cycle pulse; sampled only in IDLE.
- `n_act` in 8: activation vectors in this tile; latched at start. 0 means skip the activation and drain phases.
- `acc_en` in 1: latched at start; enables SFP accumulate strobes during drain.
- `w_base` in addr_w: weight base address; latched at start.
- `x_base` in addr_w: activation base address; latched at start.
- `p_base` in addr_w: psum write base address; latched at start.
- `l0_full` in 1: L0 full flag.
- `l0_ready` in 1: L0 non-empty, i.e. data available.
- `ofifo_valid` in 1: OFIFO holds a complete row.
- `inst` out 34: corelet instruction bus.
  - [0] load, [1] execute, [2] l0_wr, [3] l0_rd, [6] ofifo_rd, [33] sfp acc.
  - All other bits, including [4] and [5], are constant 0.
- `mem_rd` out 1: SRAM read enable; data is valid on `data_in` one cycle later.
- `mem_addr` out addr_w: SRAM read address.
- `psum_wr` out 1: psum memory write strobe.
- `psum_addr` out addr_w: psum memory write address.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on tile completion.

## Operation
States: IDLE, W_FILL, W_LOAD, W_SETTLE, X_FILL, X_EXEC, DRAIN, DONE.

- **IDLE**
  - All outputs are 0.
  - On `start`: latch the inputs, clear counters, go to W_FILL.
- **W_FILL**
  - Each cycle with `l0_full`=0 and issued<col: assert `mem_rd`, with `mem_addr` = w_base + issued, then issued++.
  - `inst[2]` (l0_wr) is `mem_rd` registered one cycle.
  - When `l0_full`=1, issue pauses. The single in-flight word is still written, so L0 must keep one entry of slack.
  - Exit to W_LOAD in the cycle after the col-th write completes.
- **W_LOAD**
  - Exactly col cycles.
  - In each cycle, assert `inst[3]` and `inst[0]` only when `l0_ready`=1. The cycle counter advances only on those cycles.
- **W_SETTLE**
  - row+col cycles with `inst`=0, letting weights propagate through the array.
  - Then go to X_FILL, or to DONE if n_act=0.
- **X_FILL**
  - Same as W_FILL, using `x_base` and count n_act.
- **X_EXEC**
  - Same as W_LOAD, asserting `inst[3]` and `inst[1]`, for n_act counted cycles.
  - Then go to DRAIN.
- **DRAIN**
  - Each cycle with `ofifo_valid`=1 and drained<n_act: assert `inst[6]`, then drained++.
  - One cycle after each `inst[6]`:
    - `psum_wr`=1 with `psum_addr` = p_base + (drained index).
    - `inst[33]` = acc_en.
  - After the n_act-th read, wait one cycle for the final `psum_wr`, then go to DONE.
- **DONE**
  - `done`=1 for one cycle, then IDLE.

Rules:
- `start` outside IDLE is ignored.
- Address arithmetic is modulo 2^addr_w; wrap is silent.
- `load` and `execute` are never high in the same cycle.
- `l0_wr` and `l0_rd` are never high in the same cycle; the phases are disjoint.

## Timing
- Reset values:
  - state = IDLE.
  - `inst`=0, `mem_rd`=0, `mem_addr`=0, `psum_wr`=0, `psum_addr`=0, `busy`=0, `done`=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `start` sampled at edge t → `busy`=1 and the first `mem_rd` both visible after edge t+1.
- Minimum tile length with no stalls: 1 + (col+1) + col + (row+col) + (n_act+1) + n_act + (n_act+1) + 1 cycles.
- A stall on `l0_full`, `l0_ready`, or `ofifo_valid` extends only the current phase. No strobe is dropped or duplicated.
- Reset asserted mid-tile: immediate return to IDLE with all outputs 0. No `done` is issued.

## Test plan
- **Full tile, no stalls.** row=col=8, n_act=16, acc_en=0, bases 0/64/128.
  - 8 `mem_rd` at addr 0–7.
  - 8 load cycles, 16 settle cycles.
  - 16 `mem_rd` at 64–79, then 16 execute cycles.
  - 16 `psum_wr` at 128–143; `inst[33]` never set.
  - `done` pulses once; cycle count matches the formula above.
- **L0 backpressure.** Hold `l0_full`=1 for 3 cycles mid X_FILL.
  - Issue pauses; exactly 16 `l0_wr` total; addresses contiguous, none skipped.
- **OFIFO gaps.** Toggle `ofifo_valid` every other cycle in DRAIN.
  - `inst[6]` only on valid cycles.
  - `psum_wr` follows each read by 1 cycle; 16 writes; with acc_en=1, `inst[33]` coincides with each `psum_wr`.
- **n_act=0.** Sequence is W phases → DONE; zero `l0_wr` after W_FILL; no `inst[1]`, `inst[6]`, or `psum_wr`.
- **Reset mid-EXEC.** Drive `reset` low during X_EXEC.
  - All outputs 0 immediately and state = IDLE.
  - A subsequent `start` runs a clean full tile.
- **Start while busy and address wrap.**
  - A second `start` pulse in DRAIN is ignored.
  - With x_base=2046 and addr_w=11, addresses run 2046, 2047, 0, 1, …
